// File: rtl/gain_mac_uni_param.sv
// Unipolar stochastic multiply-accumulate over N channels with 2^W-cycle
// bit-reversed streams; mode 0 mux-adds (sum/N), mode 1 counts every channel.
module gain_mac_uni_param #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [N-1:0][W-1:0]       iA,
  input  logic [N-1:0][W-1:0]       iB,
  output logic                      busy,
  output logic                      done,
  output logic [W+$clog2(N)-1:0]    result,
  output logic                      oC
);

  localparam int L  = $clog2(N);
  localparam int AW = W + L;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [N-1:0][W-1:0]   r_a;
  logic [N-1:0][W-1:0]   r_b;
  logic [N-1:0][W-1:0]   r_j;
  logic                  r_mode;
  logic [W-1:0]          r_k;
  logic [AW-1:0]         r_acc;
  logic [AW-1:0]         r_result;

  logic                  w_accept;
  logic                  w_last;
  logic [N-1:0]          w_abit;
  logic [N-1:0]          w_prod;
  logic [L-1:0]          w_sel;
  logic [AW-1:0]         w_pop;
  logic [AW-1:0]         w_add;
  logic [AW-1:0]         w_acc_next;

  function automatic logic [W-1:0] f_rev_w(input logic [W-1:0] x);
    for (int b = 0; b < W; b++) f_rev_w[b] = x[W-1-b];
  endfunction

  function automatic logic [L-1:0] f_rev_l(input logic [L-1:0] x);
    for (int b = 0; b < L; b++) f_rev_l[b] = x[L-1-b];
  endfunction

  // Both comparisons use the pre-increment k and j_i of this cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign w_abit[gi] = (r_a[gi] > f_rev_w(r_k));
      assign w_prod[gi] = w_abit[gi] & (r_b[gi] > f_rev_w(r_j[gi]));
    end
    if (L <= W) begin : g_sel_narrow
      assign w_sel = f_rev_l(r_k[L-1:0]);
    end else begin : g_sel_wide
      assign w_sel = f_rev_l({{(L-W){1'b0}}, r_k});
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) w_pop = w_pop + AW'(w_prod[i]);
  end

  assign w_add      = r_mode ? w_pop : AW'(w_prod[w_sel]);
  assign w_acc_next = r_acc + w_add;
  assign w_accept   = start && (r_state != S_RUN);
  assign w_last     = (r_k == {W{1'b1}});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_j      <= '0;
      r_mode   <= 1'b0;
      r_k      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a    <= iA;
        r_b    <= iB;
        r_mode <= mode;
        r_k    <= '0;
        r_j    <= '0;
        r_acc  <= '0;
      end else if (r_state == S_RUN) begin
        r_k   <= r_k + W'(1);
        r_acc <= w_acc_next;
        for (int i = 0; i < N; i++) r_j[i] <= r_j[i] + W'(w_abit[i]);
        // The last cycle's contribution goes straight into result.
        if (w_last) r_result <= w_acc_next;
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign oC     = (r_state == S_RUN) ? w_prod[w_sel] : 1'b0;

endmodule
